// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/writeback control sequencer for the 8-bit CPU datapath
module cpu_sequencer #(
    parameter int unsigned ALU_WAIT = 2,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RUN,
    output logic        IMEM_REQ,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] PC,
    output logic [2:0]  INADDRESS,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  ALUOP,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        WRITE,
    output logic        BUSY,
    output logic        ILLEGAL
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // A zero settle time still needs one EXEC cycle so WB sees stable controls.
    localparam logic [7:0] WAIT_LOAD = (ALU_WAIT == 0) ? 8'd1 : 8'(ALU_WAIT);

    localparam logic [2:0] OP_LOADI = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    // Set once an instruction has been latched; keeps decode controls at 0
    // after reset even though IR=0 would otherwise decode as loadi.
    logic        dv_q, dv_d;

    logic [2:0]  opcode;
    logic        legal;
    logic        unused_ir;

    assign opcode    = ir_q[31:29];
    assign legal     = (opcode <= OP_SUB);
    assign unused_ir = ^{ir_q[28:19], ir_q[15:11]};

    // State, PC, instruction register and wait counter; reset clears everything at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            cnt_q   <= 8'd0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
        end
    end

    // Next-state logic plus the handshake, write and illegal strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        dv_d     = dv_q;
        IMEM_REQ = 1'b0;
        WRITE    = 1'b0;
        ILLEGAL  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (RUN) state_d = S_FETCH;
            end
            S_FETCH: begin
                IMEM_REQ = 1'b1;
                if (IMEM_READY) begin
                    ir_d    = IMEM_DATA;
                    dv_d    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_EXEC;
                end else begin
                    ILLEGAL = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = RUN ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_WB;
            end
            S_WB: begin
                WRITE   = 1'b1;
                pc_d    = pc_q + PC_STEP;
                state_d = RUN ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode controls straight from the registered IR so they hold between instructions.
    always_comb begin
        INADDRESS   = 3'd0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd0;
        IMMEDIATE   = 8'd0;
        ALUOP       = 3'b000;
        IMM_SEL     = 1'b0;
        NEG_SEL     = 1'b0;
        if (dv_q) begin
            INADDRESS   = ir_q[18:16];
            OUT1ADDRESS = ir_q[10:8];
            OUT2ADDRESS = ir_q[2:0];
            IMMEDIATE   = ir_q[7:0];
            case (opcode)
                OP_LOADI: IMM_SEL = 1'b1;
                OP_ADD:   ALUOP = 3'b001;
                OP_AND:   ALUOP = 3'b010;
                OP_OR:    ALUOP = 3'b011;
                OP_SUB: begin
                    ALUOP   = 3'b001;
                    NEG_SEL = 1'b1;
                end
                default: ALUOP = 3'b000;
            endcase
        end
    end

    assign PC   = pc_q;
    assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer with a register-file datapath and reference model
module tb_cpu_sequencer;

    localparam int unsigned ALU_WAIT  = 2;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] WRAP_STEP = 32'hFFFF_FFFC;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        RUN = 1'b0;
    logic        RUN_W = 1'b0;
    logic        IMEM_READY = 1'b0;
    logic [31:0] IMEM_DATA = 32'd0;

    logic        IMEM_REQ, WRITE, BUSY, ILLEGAL, IMM_SEL, NEG_SEL;
    logic [31:0] PC;
    logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
    logic [7:0]  IMMEDIATE;

    logic        w_req, w_write, w_busy, w_illegal, w_imm_sel, w_neg_sel;
    logic [31:0] w_pc;
    logic [2:0]  w_in, w_out1, w_out2, w_aluop;
    logic [7:0]  w_imm;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = 32'd0;
    logic [7:0]  rf     [8] = '{default: 8'h00};
    logic [7:0]  ref_rf [8] = '{default: 8'h00};

    cpu_sequencer #(.ALU_WAIT(ALU_WAIT), .PC_STEP(PC_STEP)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN),
        .IMEM_REQ(IMEM_REQ), .IMEM_READY(IMEM_READY), .IMEM_DATA(IMEM_DATA),
        .PC(PC), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
        .WRITE(WRITE), .BUSY(BUSY), .ILLEGAL(ILLEGAL)
    );

    cpu_sequencer #(.ALU_WAIT(ALU_WAIT), .PC_STEP(WRAP_STEP)) u_wrap (
        .CLK(CLK), .RESET(RESET), .RUN(RUN_W),
        .IMEM_REQ(w_req), .IMEM_READY(IMEM_READY), .IMEM_DATA(IMEM_DATA),
        .PC(w_pc), .INADDRESS(w_in), .OUT1ADDRESS(w_out1), .OUT2ADDRESS(w_out2),
        .IMMEDIATE(w_imm), .ALUOP(w_aluop), .IMM_SEL(w_imm_sel), .NEG_SEL(w_neg_sel),
        .WRITE(w_write), .BUSY(w_busy), .ILLEGAL(w_illegal)
    );

    always #5 CLK = ~CLK;

    // Bench datapath: ALU and register file driven only by the sequencer's controls.
    logic [7:0] dp_a, dp_b, dp_y;
    always_comb begin
        dp_a = rf[OUT1ADDRESS];
        dp_b = IMM_SEL ? IMMEDIATE : (NEG_SEL ? (~rf[OUT2ADDRESS] + 8'd1) : rf[OUT2ADDRESS]);
        case (ALUOP)
            3'b000:  dp_y = dp_b;
            3'b001:  dp_y = dp_a + dp_b;
            3'b010:  dp_y = dp_a & dp_b;
            3'b011:  dp_y = dp_a | dp_b;
            default: dp_y = 8'h00;
        endcase
    end

    always @(posedge CLK) begin
        if (WRITE === 1'b1) rf[INADDRESS] <= dp_y;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction semantics at the architectural level.
    task automatic ref_exec(input logic [31:0] w);
        logic [7:0] a, b;
        a = ref_rf[w[10:8]];
        b = ref_rf[w[2:0]];
        case (w[31:29])
            3'd0: ref_rf[w[18:16]] = w[7:0];
            3'd1: ref_rf[w[18:16]] = a + b;
            3'd2: ref_rf[w[18:16]] = a & b;
            3'd3: ref_rf[w[18:16]] = a | b;
            3'd4: ref_rf[w[18:16]] = a - b;
            default: ;
        endcase
    endtask

    function automatic logic [2:0] exp_aluop(input logic [2:0] op);
        case (op)
            3'd1, 3'd4: return 3'b001;
            3'd2:       return 3'b010;
            3'd3:       return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at the negedge after the instruction ends.
    task automatic run_instr(input logic [31:0] w, input int delay, input bit keep_run);
        logic [2:0]  op;
        bit          legal;
        logic [2:0]  held_in;
        op      = w[31:29];
        legal   = (op <= 3'd4);
        held_in = INADDRESS;
        check("fetch_req", 32'(IMEM_REQ), 32'd1);
        check("fetch_pc", PC, model_pc);
        for (int i = 0; i < delay; i++) begin
            IMEM_READY = 1'b0;
            IMEM_DATA  = $urandom;
            @(negedge CLK);
            check("wait_req", 32'(IMEM_REQ), 32'd1);
            check("wait_pc", PC, model_pc);
            check("wait_ir_held", 32'(INADDRESS), 32'(held_in));
        end
        IMEM_READY = 1'b1;
        IMEM_DATA  = w;
        @(negedge CLK);
        IMEM_READY = 1'b0;
        IMEM_DATA  = $urandom;
        check("dec_fields", {8'h00, 5'(INADDRESS), 3'(OUT1ADDRESS), 3'(OUT2ADDRESS), 5'h00, IMMEDIATE},
              {8'h00, 5'(w[18:16]), 3'(w[10:8]), 3'(w[2:0]), 5'h00, w[7:0]});
        check("dec_illegal", 32'(ILLEGAL), 32'(!legal));
        check("dec_write", 32'(WRITE), 32'd0);
        check("dec_req", 32'(IMEM_REQ), 32'd0);
        if (legal) begin
            check("dec_ctl", {29'd0, ALUOP} | {29'd0, IMM_SEL, NEG_SEL, 1'b0} << 4,
                  {29'd0, exp_aluop(op)} | {29'd0, op == 3'd0, op == 3'd4, 1'b0} << 4);
        end
        if (!legal) begin
            RUN = keep_run;
            @(negedge CLK);
            model_pc = model_pc + PC_STEP;
        end else begin
            for (int i = 0; i < int'(ALU_WAIT); i++) begin
                @(negedge CLK);
                if (i == 0) RUN = keep_run;
                check("exec_write", 32'(WRITE), 32'd0);
                check("exec_busy", 32'(BUSY), 32'd1);
                check("exec_held", {29'd0, ALUOP}, {29'd0, exp_aluop(op)});
            end
            @(negedge CLK);
            check("wb_write", 32'(WRITE), 32'd1);
            check("wb_pc", PC, model_pc);
            ref_exec(w);
            @(negedge CLK);
            model_pc = model_pc + PC_STEP;
        end
        check("next_pc", PC, model_pc);
        check("next_req", 32'(IMEM_REQ), 32'(keep_run));
        check("next_busy", 32'(BUSY), 32'(keep_run));
        check("next_write", 32'(WRITE), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] wpc;

        // Reset state.
        #3;
        check("reset_pc", PC, 32'd0);
        check("reset_ctl", {6'd0, IMEM_REQ, WRITE, BUSY, ILLEGAL, IMM_SEL, NEG_SEL, ALUOP,
                            INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        check("idle_busy", 32'(BUSY), 32'd0);
        RUN = 1'b1;
        @(negedge CLK);

        // Directed program.
        run_instr(32'h0000_000B, 0, 1'b1);
        run_instr(32'h0001_0003, 0, 1'b1);
        run_instr(32'h8002_0001, 0, 1'b1);
        run_instr(32'h2003_0001, 0, 1'b1);
        run_instr(32'h4004_0001, 0, 1'b1);
        run_instr(32'h6005_0201, 0, 1'b1);
        check("r2", 32'(rf[2]), 32'd8);
        check("r3", 32'(rf[3]), 32'd14);
        check("r4", 32'(rf[4]), 32'd3);
        check("r5", 32'(rf[5]), 32'd11);

        // Slow memory, then an illegal opcode.
        run_instr(32'h2006_0500, 3, 1'b1);
        run_instr(32'hE000_0000, 0, 1'b1);

        // Random instruction stream with random memory wait states.
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            w[31:29] = 3'($urandom_range(0, 7));
            run_instr(w, int'($urandom_range(0, 2)), 1'b1);
        end
        for (int r = 0; r < 8; r++) begin
            check($sformatf("rf%0d", r), 32'(rf[r]), 32'(ref_rf[r]));
        end

        // Asynchronous reset between clock edges in EXEC.
        IMEM_READY = 1'b1;
        IMEM_DATA  = 32'h2007_0001;
        @(negedge CLK);
        IMEM_READY = 1'b0;
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("arst_write", 32'(WRITE), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_pc", PC, 32'd0);
        check("arst_req", 32'(IMEM_REQ), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        model_pc = 32'd0;
        @(negedge CLK);
        run_instr(32'h2001_0000, 0, 1'b0);
        check("arst_rf7", 32'(rf[7]), 32'(ref_rf[7]));
        check("arst_rf1", 32'(rf[1]), 32'(ref_rf[1]));

        // PC wrap on the second instance; main DUT stays parked and ignores IMEM_READY.
        @(negedge CLK);
        RUN_W = 1'b1;
        @(negedge CLK);
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_pc0", w_pc, 32'd0);
        IMEM_READY = 1'b1;
        IMEM_DATA  = 32'hE000_0000;
        @(negedge CLK);
        IMEM_READY = 1'b0;
        check("wrap_illegal", 32'(w_illegal), 32'd1);
        check("idle_ignore", 32'(IMEM_REQ | BUSY), 32'd0);
        @(negedge CLK);
        wpc = 32'd0 + WRAP_STEP;
        check("wrap_pc1", w_pc, wpc);
        IMEM_READY = 1'b1;
        IMEM_DATA  = 32'h0007_0055;
        @(negedge CLK);
        IMEM_READY = 1'b0;
        @(negedge CLK);
        RUN_W = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("wrap_wb_write", 32'(w_write), 32'd1);
        check("wrap_wb_pc", w_pc, wpc);
        @(negedge CLK);
        wpc = wpc + WRAP_STEP;
        check("wrap_pc2", w_pc, wpc);
        check("wrap_parked", 32'({w_busy, w_req}), 32'd0);
        check("idle_pc", PC, model_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit CPU datapath: fetches 32-bit instructions over a request/ready handshake, decodes the opcode and register fields, and drives the register-file addresses, ALU operation, operand-select controls and the register-file write strobe. Sits between instruction memory and the ALU/register-file datapath. It owns the program counter, holds each instruction's controls stable for the ALU's settle time, and issues exactly one write per legal instruction.

## Interface
- ALU_WAIT, 2: cycles spent in EXEC before writeback (ALU settle time); must be ≥1, and 0 behaves as 1.
- PC_STEP, 4: PC increment per retired or skipped instruction.

- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- RUN  in  1  enable; sampled in IDLE and at the end of WB
- IMEM_REQ  out  1  instruction fetch request
- IMEM_READY  in  1  memory has IMEM_DATA valid this cycle
- IMEM_DATA  in  32  instruction word
- PC  out  32  address of the instruction being fetched or executed
- INADDRESS  out  3  destination register, IR[18:16]
- OUT1ADDRESS  out  3  source 1 register, IR[10:8]
- OUT2ADDRESS  out  3  source 2 register, IR[2:0]
- IMMEDIATE  out  8  IR[7:0]
- ALUOP  out  3  ALU select: 000 forward, 001 add, 010 and, 011 or
- IMM_SEL  out  1  ALU data2 = IMMEDIATE
- NEG_SEL  out  1  ALU data2 = two's complement of source 2
- WRITE  out  1  register-file write strobe, one-cycle pulse
- BUSY  out  1  high whenever state ≠ IDLE
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode

## Operation
- Opcode is IR[31:29]:
  - 000 loadi: ALUOP=000, IMM_SEL=1
  - 001 add: ALUOP=001
  - 010 and: ALUOP=010
  - 011 or: ALUOP=011
  - 100 sub: ALUOP=001, NEG_SEL=1
  - 101–111 illegal
- FSM states: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE: IMEM_REQ=0. RUN=1 → FETCH.
- FETCH: IMEM_REQ=1 and held until IMEM_READY=1. On that edge, IMEM_DATA is latched into IR and the FSM moves to DECODE. IMEM_READY is ignored outside FETCH.
- DECODE (1 cycle): all decode outputs become valid from IR.
  - Legal opcode: load the wait counter with ALU_WAIT and go to EXEC.
  - Illegal opcode: ILLEGAL=1 for this cycle, no write, PC += PC_STEP, then FETCH if RUN=1, else IDLE.
- EXEC: counter decrements each cycle. Move to WB when the counter reaches 1.
- WB (1 cycle): WRITE=1, PC += PC_STEP, then FETCH if RUN=1, else IDLE.
- Decode outputs come from registered IR. They are stable from DECODE through WB and hold their last values in IDLE and FETCH. WRITE is low everywhere except WB.
- RUN falling mid-instruction does not abort it. The current instruction completes, then the FSM parks in IDLE.
- PC arithmetic is modulo 2^32: 0xFFFFFFFC + 4 → 0x00000000.

## Timing
- Reset (asynchronous, RESET=0) immediately forces all outputs to 0: PC, IMEM_REQ, WRITE, ALUOP, addresses, IMMEDIATE, IMM_SEL, NEG_SEL, BUSY, ILLEGAL. It also forces state = IDLE, IR = 0 and counter = 0.
- Reset asserted mid-instruction kills any pending WRITE the same instant. No partial writeback or PC update is retained.
- Fetch latency: 1 cycle if IMEM_READY is high in the first FETCH cycle, plus 1 cycle per ready-low cycle.
- Legal instruction with zero-wait memory: FETCH 1 + DECODE 1 + EXEC ALU_WAIT + WB 1 = 5 cycles at defaults.
- Illegal instruction with zero-wait memory: 2 cycles.
- Back-to-back with RUN=1: IMEM_REQ rises in the cycle after WB, and PC already holds the incremented value in that cycle.
- The WRITE pulse coincides with the cycle in which PC still shows the retiring instruction's address. PC updates on the edge that ends WB.

## Test plan
- Reset then RUN=1, zero-wait memory returning loadi r0,#11 (0x0000000B) → DECODE shows INADDRESS=0, IMMEDIATE=0x0B, IMM_SEL=1, ALUOP=000. WRITE pulses in cycle 5. PC=4 in cycle 6 with IMEM_REQ=1.
- Sequence loadi r1,#3; sub r2,r0,r1 (0x80020001); add; and; or → sub gives ALUOP=001, NEG_SEL=1, INADDRESS=2, OUT1ADDRESS=0, OUT2ADDRESS=1. Each instruction retires in 5 cycles, PC steps 4 each time, and the bench datapath holds r2=8, r3=14, r4=3, r5=11.
- IMEM_READY held low 3 cycles in FETCH → IMEM_REQ stays high for 4 cycles, IR changes only on the ready edge, PC unchanged.
- Opcode 111 (0xE0000000) → ILLEGAL pulses 1 cycle in DECODE, no WRITE, PC += 4, next FETCH 2 cycles after the previous WB.
- RESET driven low mid-EXEC (between clock edges) → WRITE, BUSY and PC go to 0 without waiting for a clock edge. After release with RUN=1, fetch restarts at PC=0.
- PC preset to 0xFFFFFFFC, one legal instruction with RUN dropped during EXEC → WB completes, PC=0x00000000, FSM in IDLE with BUSY=0 and IMEM_REQ=0.
